lut_cfg_writer: RTL and testbench

Runtime-reconfigurable 4-input LUT with a serial configuration writer. Accepts a 16-bit truth table over a valid/ready port, shifts it bit-serially into a shadow register, then commits it atomically to the active table that drives the combinational LUT output. It is the write side of the fixed-INIT LUT primitive: the same lookup function, but loaded at run time by configuration logic.

---
 rtl/lut_cfg_writer.sv | 87 ++++++++
 tb/tb_lut_cfg_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_writer.sv
// Run-time loadable 4-input LUT: a 16-bit truth table is shifted MSB first into a shadow register, then committed atomically.
// Optional serial readback of the previous table is enabled with the LUT_CFG_READBACK_EN macro.
module lut_cfg_writer #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cfg_data_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output logic        busy_o,
    output logic        cfg_done_o,
`ifdef LUT_CFG_READBACK_EN
    output logic        cfg_dout_o,
`endif
    input  logic [3:0]  lut_i,
    output logic        lut_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_table;
    logic [15:0] r_shadow;
    logic [15:0] r_load;
    logic [3:0]  r_cnt;
    logic        r_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_table  <= INIT;
            r_shadow <= 16'h0000;
            r_load   <= 16'h0000;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        r_load <= cfg_data_i;
`ifdef LUT_CFG_READBACK_EN
                        // Preloading the old table lets it stream out of shadow[15] as the new word shifts in.
                        r_shadow <= r_table;
`else
                        r_shadow <= 16'h0000;
`endif
                        r_cnt   <= 4'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shadow <= {r_shadow[14:0], r_load[15]};
                    r_load   <= {r_load[14:0], 1'b0};
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_table <= r_shadow;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign cfg_done_o  = r_done;
`ifdef LUT_CFG_READBACK_EN
    assign cfg_dout_o  = (r_state == S_SHIFT) ? r_shadow[15] : 1'b0;
`endif

    // Only the committed table drives the lookup, so a partial load is never visible.
    assign lut_o = r_table[lut_i];

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Bench for lut_cfg_writer: directed scenarios with randomized side inputs, checked against a transaction-level model.
module tb_lut_cfg_writer;

    localparam logic [15:0] INIT = 16'h8001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        busy;
    logic        cfg_done;
    logic [3:0]  lut_idx;
    logic        lut_out;
`ifdef LUT_CFG_READBACK_EN
    logic        cfg_dout;
`endif

    lut_cfg_writer #(.INIT(INIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_data_i  (cfg_data),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .busy_o      (busy),
        .cfg_done_o  (cfg_done),
`ifdef LUT_CFG_READBACK_EN
        .cfg_dout_o  (cfg_dout),
`endif
        .lut_i       (lut_idx),
        .lut_o       (lut_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a word is accepted when idle, and committed 17 edges later.
    logic [15:0] m_table;
    logic [15:0] m_word;
    logic        m_busy;
    logic        m_done;
    int          m_age;
    int          m_accepts;
    int          m_dones;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_table = INIT;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (cfg_valid) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                    m_word = cfg_data;
                    m_accepts++;
                end
            end else begin
                m_age++;
                if (m_age == 18) begin
                    m_table = m_word;
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                    m_age   = 0;
                    m_dones++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_dout;
        chk("ready", {15'd0, cfg_ready}, {15'd0, ~m_busy});
        chk("busy", {15'd0, busy}, {15'd0, m_busy});
        chk("done", {15'd0, cfg_done}, {15'd0, m_done});
        chk("lut_o", {15'd0, lut_out}, {15'd0, m_table[lut_idx]});
        exp_dout = 1'b0;
        if (m_busy && m_age <= 16) exp_dout = m_table[16 - m_age];
`ifdef LUT_CFG_READBACK_EN
        chk("dout", {15'd0, cfg_dout}, {15'd0, exp_dout});
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        lut_idx = 4'($urandom);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [15:0] init_v;
        logic [15:0] seq_v;
        int          dones_before;
        init_v       = INIT;
        m_table      = 16'h0000;
        m_word       = 16'h0000;
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_age        = 0;
        m_accepts    = 0;
        m_dones      = 0;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_data     = 16'h0000;
        lut_idx      = 4'd0;

        // Reset and sweep the INIT table
        run(2);
        rst = 1'b0;
        run(1);
        for (int i = 0; i < 16; i++) begin
            lut_idx = 4'(i);
            #1;
            chk("init_sweep", {15'd0, lut_out}, {15'd0, init_v[i]});
        end
        chk("rst_ready", {15'd0, cfg_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, cfg_done}, 16'd0);

        // Load A5C3, noise on valid/data during the load
        cfg_valid = 1'b1;
        cfg_data  = 16'hA5C3;
        cyc();
        for (int i = 1; i <= 17; i++) begin
            cfg_valid = 1'($urandom);
            cfg_data  = 16'($urandom);
            cyc();
        end
        cfg_valid = 1'b0;
        run(3);
        for (int i = 0; i < 16; i++) begin
            lut_idx = 4'(i);
            #1;
            seq_v = 16'hA5C3;
            chk("a5c3_sweep", {15'd0, lut_out}, {15'd0, seq_v[i]});
        end

        // Back-to-back loads with valid held high
        cfg_valid = 1'b1;
        cfg_data  = 16'h1234;
        cyc();
        cfg_data  = 16'hFFFF;
        run(36);
        cfg_valid = 1'b0;
        run(20);
        chk("b2b_table", {15'd0, lut_out}, {15'd0, 1'b1});
        chk("accepts", 16'(m_accepts), 16'd4);

        // Reset in the middle of a 0F0F load
        dones_before = m_dones;
        cfg_valid = 1'b1;
        cfg_data  = 16'h0F0F;
        cyc();
        cfg_valid = 1'b0;
        run(7);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(30);
        chk("abort_no_done", 16'(m_dones), 16'(dones_before));

        // Readback: table A5C3 then load 0000
        cfg_valid = 1'b1;
        cfg_data  = 16'hA5C3;
        cyc();
        cfg_valid = 1'b0;
        run(18);
        cfg_valid = 1'b1;
        cfg_data  = 16'h0000;
        cyc();
        cfg_valid = 1'b0;
        run(20);

        // Random words and random valid
        for (int i = 0; i < 400; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_data  = 16'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
